// File: rtl/traffic_request_conditioner_pkg.sv
// Shared types and default parameters for the traffic request conditioner and its controller.
package traffic_request_conditioner_pkg;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int RETRY_DEF      = 16;
  localparam int WINDOW_DEF     = 32;
  localparam int CNT_W_DEF      = 6;
  localparam int OVL_THRESH_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_SERVED = 2'd3
  } req_state_e;

endpackage

// File: rtl/traffic_request_conditioner_if.sv
// Kerbside inputs, walk feedback and conditioned request outputs of the conditioner.
interface traffic_request_conditioner_if
  import traffic_request_conditioner_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             raw_btn_NS;
  logic             raw_btn_EW;
  logic             loop_NS;
  logic             loop_EW;
  logic             walk_NS;
  logic             walk_EW;
  logic             button_NS;
  logic             button_EW;
  logic             vehicle_overload;
  logic             pend_NS;
  logic             pend_EW;
  logic [CNT_W-1:0] veh_cnt_NS;
  logic [CNT_W-1:0] veh_cnt_EW;

  modport master (
    output raw_btn_NS, raw_btn_EW, loop_NS, loop_EW, walk_NS, walk_EW,
    input  button_NS, button_EW, vehicle_overload, pend_NS, pend_EW,
    input  veh_cnt_NS, veh_cnt_EW
  );

  modport slave (
    input  raw_btn_NS, raw_btn_EW, loop_NS, loop_EW, walk_NS, walk_EW,
    output button_NS, button_EW, vehicle_overload, pend_NS, pend_EW,
    output veh_cnt_NS, veh_cnt_EW
  );
endinterface

// File: rtl/traffic_request_conditioner_debounce.sv
// Two-flop synchroniser plus consecutive-sample filter for one asynchronous level.
// rise_o is a registered one-cycle pulse coinciding with the first cycle of a debounced high.
module traffic_request_conditioner_debounce
  import traffic_request_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
)(
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic rise_o
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic          rise_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) deb_d = sync2_q;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      rise_q  <= deb_d & ~deb_q;
    end
  end

  assign rise_o = rise_q;
endmodule

// File: rtl/traffic_request_conditioner.sv
// Conditions pedestrian buttons and loop detectors into clean request pulses for the light controller.
// Request FSM (one per direction, index 0 = NS, 1 = EW):
//   state     | meaning
//   ST_IDLE   | no request outstanding
//   ST_REQ    | one-cycle request pulse, retry timer reloaded
//   ST_WAIT   | request pending, waiting for walk or retry expiry
//   ST_SERVED | walk active, further presses dropped until walk falls
module traffic_request_conditioner
  import traffic_request_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int RETRY      = RETRY_DEF,
  parameter int WINDOW     = WINDOW_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int OVL_THRESH = OVL_THRESH_DEF
)(
  input logic                          clk,
  input logic                          rst_n,
  traffic_request_conditioner_if.slave bus
);
  localparam int RTW = $clog2(RETRY + 1);
  localparam logic [RTW-1:0] RETRY_LOAD = RTW'(RETRY - 1);
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] OVL_TH = CNT_W'(OVL_THRESH);

  logic [1:0] raw_btn, raw_loop, rise_btn, rise_loop, walk;

  req_state_e           state_q [2];
  req_state_e           state_d [2];
  logic [1:0][RTW-1:0]  retry_q, retry_d;
  logic [1:0]           button_q, button_d;
  logic [1:0]           pend_q, pend_d;
  logic [1:0][CNT_W-1:0] veh_q, veh_d;
  logic [WW-1:0]        win_q, win_d;
  logic                 win_tc;
  logic                 ovl_q, ovl_d;

  assign raw_btn  = {bus.raw_btn_EW, bus.raw_btn_NS};
  assign raw_loop = {bus.loop_EW, bus.loop_NS};
  assign walk     = {bus.walk_EW, bus.walk_NS};

  for (genvar g = 0; g < 2; g++) begin : g_dir
    traffic_request_conditioner_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (raw_btn[g]),
      .rise_o (rise_btn[g])
    );
    traffic_request_conditioner_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_loop_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (raw_loop[g]),
      .rise_o (rise_loop[g])
    );
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      retry_d[i] = retry_q[i];
      unique case (state_q[i])
        ST_IDLE:   if (rise_btn[i]) state_d[i] = walk[i] ? ST_SERVED : ST_REQ;
        ST_REQ:    state_d[i] = ST_WAIT;
        // walk wins over a coincident retry expiry
        ST_WAIT: begin
          if (walk[i])                state_d[i] = ST_SERVED;
          else if (retry_q[i] == '0)  state_d[i] = ST_REQ;
        end
        ST_SERVED: if (!walk[i]) state_d[i] = ST_IDLE;
        default:   state_d[i] = ST_IDLE;
      endcase
      if (state_d[i] == ST_REQ)  retry_d[i] = RETRY_LOAD;
      else if (retry_q[i] != '0) retry_d[i] = retry_q[i] - 1'b1;
      button_d[i] = (state_d[i] == ST_REQ);
      pend_d[i]   = (state_d[i] == ST_REQ) || (state_d[i] == ST_WAIT);
    end
  end

  assign win_tc = (win_q == WIN_LAST);
  assign win_d  = win_tc ? '0 : win_q + 1'b1;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (win_tc)                                veh_d[i] = CNT_W'(rise_loop[i]);
      else if (rise_loop[i] && veh_q[i] != CNT_MAX) veh_d[i] = veh_q[i] + 1'b1;
      else                                       veh_d[i] = veh_q[i];
    end
    ovl_d = win_tc && ((veh_q[0] >= OVL_TH) || (veh_q[1] >= OVL_TH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) state_q[i] <= ST_IDLE;
      retry_q  <= '0;
      button_q <= '0;
      pend_q   <= '0;
      veh_q    <= '0;
      win_q    <= '0;
      ovl_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) state_q[i] <= state_d[i];
      retry_q  <= retry_d;
      button_q <= button_d;
      pend_q   <= pend_d;
      veh_q    <= veh_d;
      win_q    <= win_d;
      ovl_q    <= ovl_d;
    end
  end

  assign bus.button_NS        = button_q[0];
  assign bus.button_EW        = button_q[1];
  assign bus.pend_NS          = pend_q[0];
  assign bus.pend_EW          = pend_q[1];
  assign bus.veh_cnt_NS       = veh_q[0];
  assign bus.veh_cnt_EW       = veh_q[1];
  assign bus.vehicle_overload = ovl_q;
endmodule
